// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types, defaults and the ROM address check for the
// boot-ROM arbiter.
//   ROM_BASE_DEF / ROM_SIZE_DEF : default ROM window (byte addresses)
//   port_e                      : requester identifier, also the slot index
//   rom_rsp_t                   : packed view of one response slot
//   in_rom_range()              : 1 when an access is word aligned and the
//                                 whole word lies inside the ROM window;
//                                 a fault is the inverse
package rom_arb_pkg;

   localparam logic [31:0] ROM_BASE_DEF = 32'hBFC0_0000;
   localparam int          ROM_SIZE_DEF = 4096;

   typedef enum logic {
      PORT_F = 1'b0,
      PORT_D = 1'b1
   } port_e;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } rom_rsp_t;

   function automatic logic in_rom_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
      logic [31:0] last_word;
      last_word = base + size - 32'd4;
      return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= last_word);
   endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: request/response bundle for both requesters plus the ROM
// port of the arbiter.
//   f_* : instruction-fetch request, response and flush
//   d_* : data-side load request and response
//   mem_addr_o / mem_rd_i : combinational-read ROM port
// Modports: slave = arbiter side, master = requesters/ROM side.
interface rom_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  f_req_valid_i;
   logic                  f_req_ready_o;
   logic [ADDR_WIDTH-1:0] f_addr_i;
   logic                  f_rsp_valid_o;
   logic                  f_rsp_ready_i;
   logic [DATA_WIDTH-1:0] f_rsp_data_o;
   logic                  f_rsp_err_o;
   logic                  f_flush_i;

   logic                  d_req_valid_i;
   logic                  d_req_ready_o;
   logic [ADDR_WIDTH-1:0] d_addr_i;
   logic                  d_rsp_valid_o;
   logic                  d_rsp_ready_i;
   logic [DATA_WIDTH-1:0] d_rsp_data_o;
   logic                  d_rsp_err_o;

   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_rd_i;

   modport slave (
      input  f_req_valid_i, f_addr_i, f_rsp_ready_i, f_flush_i,
      input  d_req_valid_i, d_addr_i, d_rsp_ready_i,
      input  mem_rd_i,
      output f_req_ready_o, f_rsp_valid_o, f_rsp_data_o, f_rsp_err_o,
      output d_req_ready_o, d_rsp_valid_o, d_rsp_data_o, d_rsp_err_o,
      output mem_addr_o
   );

   modport master (
      output f_req_valid_i, f_addr_i, f_rsp_ready_i, f_flush_i,
      output d_req_valid_i, d_addr_i, d_rsp_ready_i,
      output mem_rd_i,
      input  f_req_ready_o, f_rsp_valid_o, f_rsp_data_o, f_rsp_err_o,
      input  d_req_ready_o, d_rsp_valid_o, d_rsp_data_o, d_rsp_err_o,
      input  mem_addr_o
   );
endinterface

// File: rtl/rom_arb_rsp_slot.sv
// rom_arb_rsp_slot: one registered response slot.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   load_i            : a request was granted this cycle; capture its result
//   load_err_i        : the granted access faulted (data forced to 0)
//   load_data_i       : ROM word for the granted access
//   rsp_ready_i       : consumer takes the held response this cycle
//   flush_i           : drop the held response at the edge
//   rsp_valid_o / rsp_err_o / rsp_data_o : held response
module rom_arb_rsp_slot
   import rom_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  load_err_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   input  logic                  rsp_ready_i,
   input  logic                  flush_i,
   output logic                  rsp_valid_o,
   output logic                  rsp_err_o,
   output logic [DATA_WIDTH-1:0] rsp_data_o
);
   logic                  valid_reg;
   logic                  err_reg;
   logic [DATA_WIDTH-1:0] data_reg;

   // A new grant has priority over flush/drain: a request accepted in the
   // same cycle as a flush or a consume is the one that must survive.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         data_reg  <= '0;
      end else if (load_i) begin
         valid_reg <= 1'b1;
         err_reg   <= load_err_i;
         data_reg  <= load_err_i ? '0 : load_data_i;
      end else if (flush_i || (valid_reg && rsp_ready_i)) begin
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         data_reg  <= '0;
      end
   end

   assign rsp_valid_o = valid_reg;
   assign rsp_err_o   = err_reg;
   assign rsp_data_o  = data_reg;
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational-read boot ROM between instruction
// fetch (F) and data-side loads (D). At most one request is granted per
// cycle; its result is registered into that port's response slot, so a
// grant in cycle N is visible as a response in N+1 and is held until the
// port's rsp_ready.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : rom_arbiter_if.slave (requests, responses, flush, ROM port)
// Build option: define ROM_ARB_RR_EN to replace fixed D-priority with its
// fetch starvation escape by a round-robin grant between F and D.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = ROM_BASE_DEF,
   parameter int                    ROM_SIZE   = ROM_SIZE_DEF,
   parameter int                    STARVE_MAX = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   rom_arbiter_if.slave  bus
);
   logic elig_f, elig_d;
   logic grant_f, grant_d;
   logic fault_f, fault_d;

   logic [1:0]            slot_load, slot_err, slot_ready, slot_flush;
   logic [1:0]            slot_valid, slot_rsp_err;
   logic [DATA_WIDTH-1:0] slot_data [2];

   // A port may be granted only if its slot is free or draining this cycle.
   assign elig_f = bus.f_req_valid_i && (!slot_valid[PORT_F] || bus.f_rsp_ready_i);
   assign elig_d = bus.d_req_valid_i && (!slot_valid[PORT_D] || bus.d_rsp_ready_i);

   assign fault_f = !in_rom_range(32'(bus.f_addr_i), 32'(ROM_BASE), 32'(ROM_SIZE));
   assign fault_d = !in_rom_range(32'(bus.d_addr_i), 32'(ROM_BASE), 32'(ROM_SIZE));

`ifdef ROM_ARB_RR_EN
   port_e rr_reg, rr_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) rr_reg <= PORT_F;
      else       rr_reg <= rr_next;
   end

   // Pointer only moves on a contended grant; a lone requester leaves it.
   always_comb begin
      grant_f = 1'b0;
      grant_d = 1'b0;
      rr_next = rr_reg;
      if (elig_f && elig_d) begin
         if (rr_reg == PORT_F) begin
            grant_f = 1'b1;
            rr_next = PORT_D;
         end else begin
            grant_d = 1'b1;
            rr_next = PORT_F;
         end
      end else begin
         grant_f = elig_f;
         grant_d = elig_d;
      end
   end
`else
   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_reg, starve_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) starve_reg <= '0;
      else       starve_reg <= starve_next;
   end

   // D normally wins; once fetch has been passed over STARVE_MAX times in a
   // row it takes the next contended cycle.
   always_comb begin
      grant_d     = elig_d && !(elig_f && (starve_reg == STARVE_LIM));
      grant_f     = elig_f && !grant_d;
      starve_next = '0;
      if (elig_f && !grant_f)
         starve_next = (starve_reg == STARVE_LIM) ? starve_reg
                                                  : starve_reg + CNT_W'(1);
   end
`endif

   // Faulting or idle cycles park the ROM on its base so the ROM index
   // never leaves the array.
   always_comb begin
      bus.mem_addr_o = ROM_BASE;
      if (grant_d && !fault_d)
         bus.mem_addr_o = bus.d_addr_i;
      else if (grant_f && !fault_f)
         bus.mem_addr_o = bus.f_addr_i;
   end

   assign bus.f_req_ready_o = grant_f;
   assign bus.d_req_ready_o = grant_d;

   assign slot_load[PORT_F]  = grant_f;
   assign slot_load[PORT_D]  = grant_d;
   assign slot_err[PORT_F]   = fault_f;
   assign slot_err[PORT_D]   = fault_d;
   assign slot_ready[PORT_F] = bus.f_rsp_ready_i;
   assign slot_ready[PORT_D] = bus.d_rsp_ready_i;
   assign slot_flush[PORT_F] = bus.f_flush_i;
   assign slot_flush[PORT_D] = 1'b0;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         rom_arb_rsp_slot #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_i      (slot_load[gi]),
            .load_err_i  (slot_err[gi]),
            .load_data_i (bus.mem_rd_i),
            .rsp_ready_i (slot_ready[gi]),
            .flush_i     (slot_flush[gi]),
            .rsp_valid_o (slot_valid[gi]),
            .rsp_err_o   (slot_rsp_err[gi]),
            .rsp_data_o  (slot_data[gi])
         );
      end
   endgenerate

   assign bus.f_rsp_valid_o = slot_valid[PORT_F];
   assign bus.f_rsp_err_o   = slot_rsp_err[PORT_F];
   assign bus.f_rsp_data_o  = slot_data[PORT_F];
   assign bus.d_rsp_valid_o = slot_valid[PORT_D];
   assign bus.d_rsp_err_o   = slot_rsp_err[PORT_D];
   assign bus.d_rsp_data_o  = slot_data[PORT_D];
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table-driven bench for rom_arbiter. Each vector drives one
// cycle of inputs and states the expected grants; granted accesses push the
// expected response (from a local ROM model and address check) onto a
// per-port scoreboard queue that is compared against the response slot
// after the edge.
module tb_rom_arbiter;
   localparam logic [31:0] BASE = 32'hBFC0_0000;

   typedef struct {
      logic        rst;
      logic        fv;
      logic [31:0] fa;
      logic        dv;
      logic [31:0] da;
      logic        frr;
      logic        drr;
      logic        fl;
      logic        efr;
      logic        edr;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rom_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   rom_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .ROM_BASE   (BASE),
      .ROM_SIZE   (4096),
      .STARVE_MAX (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == BASE) return 32'h0050_0093;
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < BASE) || (a > BASE + 32'd4092);
   endfunction

   always_comb bus.mem_rd_i = rom_word(bus.mem_addr_o);

   vec_t vecs[$];
   exp_t fq[$];
   exp_t dq[$];
   int   checks = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic void v(input logic r, input logic fv, input logic [31:0] fa,
                             input logic dv, input logic [31:0] da,
                             input logic frr, input logic drr, input logic fl,
                             input logic efr, input logic edr);
      vec_t t;
      t.rst = r; t.fv = fv; t.fa = fa; t.dv = dv; t.da = da;
      t.frr = frr; t.drr = drr; t.fl = fl; t.efr = efr; t.edr = edr;
      vecs.push_back(t);
   endfunction

   // n cycles of continuous contention from a freshly cleared arbitration state
   function automatic void contend(input int n, input logic [31:0] off);
      logic f_wins;
      for (int k = 0; k < n; k++) begin
`ifdef ROM_ARB_RR_EN
         f_wins = ((k % 2) == 0);
`else
         f_wins = ((k % 5) == 4);
`endif
         v(0, 1, BASE + off + 32'(4 * k), 1, BASE + off + 32'h100 + 32'(4 * k),
           1, 1, 0, f_wins, !f_wins);
      end
   endfunction

   task automatic run(input vec_t t);
      logic [31:0] em;
      exp_t e;
      rst               = t.rst;
      bus.f_req_valid_i = t.fv;
      bus.f_addr_i      = t.fa;
      bus.d_req_valid_i = t.dv;
      bus.d_addr_i      = t.da;
      bus.f_rsp_ready_i = t.frr;
      bus.d_rsp_ready_i = t.drr;
      bus.f_flush_i     = t.fl;
      @(negedge clk);
      if (!t.rst) begin
         check("f_req_ready", 64'(bus.f_req_ready_o), 64'(t.efr));
         check("d_req_ready", 64'(bus.d_req_ready_o), 64'(t.edr));
         em = BASE;
         if (t.edr && !bad_addr(t.da))      em = t.da;
         else if (t.efr && !bad_addr(t.fa)) em = t.fa;
         check("mem_addr", 64'(bus.mem_addr_o), 64'(em));
      end
      @(posedge clk);
      if (t.rst) begin
         fq.delete();
         dq.delete();
      end else begin
         if (t.efr) begin
            if (fq.size() > 0) void'(fq.pop_front());
            e.err  = bad_addr(t.fa);
            e.data = e.err ? 32'h0 : rom_word(t.fa);
            fq.push_back(e);
         end else if ((t.fl || t.frr) && fq.size() > 0) begin
            void'(fq.pop_front());
         end
         if (t.edr) begin
            if (dq.size() > 0) void'(dq.pop_front());
            e.err  = bad_addr(t.da);
            e.data = e.err ? 32'h0 : rom_word(t.da);
            dq.push_back(e);
         end else if (t.drr && dq.size() > 0) begin
            void'(dq.pop_front());
         end
      end
      #1;
      if (t.rst) begin
         check("f_rsp_after_reset",
               64'({bus.f_rsp_valid_o, bus.f_rsp_err_o, bus.f_rsp_data_o}), 64'(0));
         check("d_rsp_after_reset",
               64'({bus.d_rsp_valid_o, bus.d_rsp_err_o, bus.d_rsp_data_o}), 64'(0));
      end else begin
         if (fq.size() > 0)
            check("f_rsp", 64'({bus.f_rsp_valid_o, bus.f_rsp_err_o, bus.f_rsp_data_o}),
                  64'({1'b1, fq[0].err, fq[0].data}));
         else
            check("f_rsp_valid", 64'(bus.f_rsp_valid_o), 64'(0));
         if (dq.size() > 0)
            check("d_rsp", 64'({bus.d_rsp_valid_o, bus.d_rsp_err_o, bus.d_rsp_data_o}),
                  64'({1'b1, dq[0].err, dq[0].data}));
         else
            check("d_rsp_valid", 64'(bus.d_rsp_valid_o), 64'(0));
      end
      $display("vec rst=%0b f=%0b@%h d=%0b@%h frr=%0b drr=%0b fl=%0b | fr=%0b dr=%0b f_rsp=%0b/%0b/%h d_rsp=%0b/%0b/%h",
               t.rst, t.fv, t.fa, t.dv, t.da, t.frr, t.drr, t.fl,
               t.efr, t.edr, bus.f_rsp_valid_o, bus.f_rsp_err_o, bus.f_rsp_data_o,
               bus.d_rsp_valid_o, bus.d_rsp_err_o, bus.d_rsp_data_o);
   endtask

   initial begin
      bus.f_req_valid_i = 1'b0;
      bus.f_addr_i      = '0;
      bus.d_req_valid_i = 1'b0;
      bus.d_addr_i      = '0;
      bus.f_rsp_ready_i = 1'b0;
      bus.d_rsp_ready_i = 1'b0;
      bus.f_flush_i     = 1'b0;

      //  rst fv fa             dv da               frr drr fl efr edr
      v(1, 0, 0,             0, 0,              0, 0, 0, 0, 0);   // reset
      v(0, 1, BASE,          0, 0,              1, 1, 0, 1, 0);   // lone F fetch
      v(0, 0, 0,             0, 0,              1, 1, 0, 0, 0);
      contend(10, 32'h10);                                         // arbitration pattern
      v(0, 0, 0,             0, 0,              1, 1, 0, 0, 0);
      v(0, 0, 0,             1, BASE + 32'h2,   1, 1, 0, 0, 1);   // misaligned
      v(0, 0, 0,             1, BASE + 32'h1000,1, 1, 0, 0, 1);   // one past end
      v(0, 0, 0,             1, BASE + 32'hFFC, 1, 1, 0, 0, 1);   // last valid word
      v(0, 1, BASE - 32'h4,  0, 0,              1, 1, 0, 1, 0);   // below base
      v(0, 0, 0,             0, 0,              1, 1, 0, 0, 0);
      v(0, 1, BASE + 32'h20, 0, 0,              0, 1, 0, 1, 0);   // backpressure
      v(0, 1, BASE + 32'h24, 0, 0,              0, 1, 0, 0, 0);   // held, blocked
      v(0, 1, BASE + 32'h24, 0, 0,              1, 1, 0, 1, 0);   // drain + refill
      v(0, 0, 0,             0, 0,              1, 1, 0, 0, 0);
      v(0, 1, BASE + 32'h30, 0, 0,              0, 1, 0, 1, 0);   // flush sequence
      v(0, 1, BASE + 32'h10, 0, 0,              1, 1, 1, 1, 0);   // flush + new grant
      v(0, 0, 0,             1, BASE + 32'h44,  0, 1, 0, 0, 1);   // F held, D granted
      v(0, 0, 0,             0, 0,              0, 0, 1, 0, 0);   // flush drops F only
      v(0, 0, 0,             0, 0,              1, 1, 0, 0, 0);
      contend(3, 32'h80);                                          // build up arbitration state
      v(1, 1, BASE,          1, BASE + 32'h4,   1, 1, 0, 0, 0);   // reset mid-contention
      contend(5, 32'h200);                                         // must restart from reset state
      v(0, 0, 0,             0, 0,              1, 1, 0, 0, 0);
      v(0, 1, BASE + 32'h8,  0, 0,              0, 0, 0, 1, 0);   // F slot held
      v(0, 1, BASE + 32'h8,  1, BASE + 32'hC,   0, 0, 0, 0, 1);   // D slot held too
      v(1, 1, BASE + 32'h8,  1, BASE + 32'hC,   0, 0, 0, 0, 0);   // reset drops both

      for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single combinational-read boot ROM (byte-addressed, base 0xBFC00000, little-endian word assembly inside the ROM) between two requesters: instruction fetch (port F) and data-side loads from the ROM region (port D).
- Accepts at most one request per cycle and drives the ROM address.
- Registers the returned word into a per-port response slot, so responses have one-cycle latency with backpressure.
- Sits between the fetch/LSU stages and the instruction memory.

Parameters:
- ADDR_WIDTH, 32, address width of requests and ROM port.
- DATA_WIDTH, 32, word width of ROM read data and responses.
- ROM_BASE, 32'hBFC00000, first valid byte address.
- ROM_SIZE, 4096, ROM size in bytes (power of two).
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win (width = $clog2(STARVE_MAX+1)).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- f_req_valid_i  in  1  fetch request valid
- f_req_ready_o  out  1  fetch request accepted this cycle
- f_addr_i  in  ADDR_WIDTH  fetch byte address
- f_rsp_valid_o  out  1  fetch response valid
- f_rsp_ready_i  in  1  fetch response consumed
- f_rsp_data_o  out  DATA_WIDTH  fetch response word
- f_rsp_err_o  out  1  fetch access fault
- f_flush_i  in  1  discard pending fetch response (redirect)
- d_req_valid_i, d_req_ready_o, d_addr_i, d_rsp_valid_o, d_rsp_ready_i, d_rsp_data_o, d_rsp_err_o  same as F equivalents, data port
- mem_addr_o  out  ADDR_WIDTH  address to ROM
- mem_rd_i  in  DATA_WIDTH  ROM read data (combinational from mem_addr_o)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: all rsp_valid 0, rsp_data 0, rsp_err 0, starve counter 0, RR pointer = F. Responses pending at reset are dropped.
- Eligibility: eligible_X = X_req_valid_i && (!X_rsp_valid_o || X_rsp_ready_i). A draining slot can be refilled in the same cycle.
- Fixed-priority grant (default):
  - D wins when both ports are eligible.
  - F wins instead when starve_cnt == STARVE_MAX.
  - A lone eligible port wins.
- Handshake: X_req_ready_o = grant_X. It depends combinationally on the valids and on rsp_ready. A request transfers when valid && ready.
- Starve counter:
  - Increments, saturating at STARVE_MAX, when F is eligible but not granted.
  - Clears when F is granted or F is not eligible.
- Address check (request cycle): fault if addr[1:0] != 0 or addr < ROM_BASE or addr > ROM_BASE+ROM_SIZE-4.
- mem_addr_o:
  - Granted address when there is a grant and no fault.
  - ROM_BASE otherwise, so the ROM index never goes out of range.
- Latency: a grant in cycle N gives X_rsp_valid_o=1 in N+1.
  - rsp_data = mem_rd_i on a good access; 0 with rsp_err=1 on a fault.
  - Response holds stable until X_rsp_ready_i.
- Slot clear: the slot clears on ready without a new grant.
- f_flush_i:
  - Clears the F response slot at the edge.
  - A request granted in the flush cycle is kept: its response appears in N+1.
  - Flush has no effect on D.
- No combinational path from mem_rd_i to any output.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: round-robin grant replaces fixed priority and the starve counter.
  - The pointer names the preferred port.
  - When both ports are eligible, the preferred port wins and the pointer toggles to the other port after each contended grant.
  - A lone eligible port always wins; the pointer is unchanged.
- Undefined: fixed priority with the starvation escape as specified above.

Decomposition:
- Package rom_arb_pkg holds:
  - ROM_BASE_DEF and ROM_SIZE_DEF constants.
  - typedef enum logic {PORT_F, PORT_D} port_e.
  - typedef struct packed {logic valid; logic err; logic [31:0] data;} rom_rsp_t.
  - Function in_rom_range(addr) returning the fault check.
- Sub-module rom_arb_rsp_slot: one response register with load/ready/flush. It is instantiated twice.

Test Plan:
- Reset, then F requests 0xBFC00000 alone, ROM word 0x00500093: f_req_ready_o=1 in N; f_rsp_valid_o=1 with data 0x00500093 and err=0 in N+1; d_rsp_valid_o stays 0.
- F and D both valid continuously, rsp_ready held 1, STARVE_MAX=4: D granted 4 cycles, then F granted on the 5th, and the pattern repeats. With ROM_ARB_RR_EN, grants alternate F,D,F,D.
- D requests 0xBFC00002 (misaligned), then 0xBFC01000 (out of range): both give d_rsp_err_o=1, data 0, and mem_addr_o=0xBFC00000 in each request cycle.
- F response pending with f_rsp_ready_i=0 and F valid again: f_req_ready_o=0 and the slot holds. Raise ready: new grant the same cycle, back-to-back response next cycle.
- F response pending, f_flush_i=1 with a new F request 0xBFC00010 granted that cycle: the old response is dropped and the next-cycle response carries the 0xBFC00010 word.
- rst_i asserted while both slots are valid: next cycle all rsp_valid=0, data=0, starve_cnt=0.
